// File: rtl/rc4_xor_stream.sv
// ----------------------------------------------------------------------------
// rc4_xor_stream
//
// Consumer side of the RC4 keystream interface. Keystream bytes arrive from
// the key generator over a valid/ready handshake and are prefetched into a
// small FIFO. Each data byte is XORed with the oldest prefetched keystream
// byte. Encryption and decryption are the same operation.
//
// A message of msg_len bytes fetches exactly msg_len keystream bytes. That
// way the generator stays byte-aligned from one message to the next.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : asynchronous reset, active low
//   start      : 1-cycle pulse that begins a message (honoured in IDLE only)
//   msg_len    : message length in bytes, sampled when start is accepted
//   busy       : high from the accepted start through the done pulse
//   done       : 1-cycle pulse after the last output byte is handed off
//   ks_data    : keystream byte from the generator
//   ks_valid   : generator offers a keystream byte
//   ks_ready   : this block accepts ks_data this cycle
//   din        : plaintext/ciphertext byte
//   din_valid  : din is valid
//   din_ready  : this block accepts din this cycle
//   dout       : din XOR keystream (registered)
//   dout_valid : dout is valid (registered)
//   dout_ready : downstream accepts dout
// ----------------------------------------------------------------------------
module rc4_xor_stream #(
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len,
    output logic             busy,
    output logic             done,
    input  logic [7:0]       ks_data,
    input  logic             ks_valid,
    output logic             ks_ready,
    input  logic [7:0]       din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [7:0]       dout,
    output logic             dout_valid,
    input  logic             dout_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_ZERO = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_reg;
    logic [LEN_W-1:0] ks_rem_reg;   // keystream bytes still to fetch
    logic [LEN_W-1:0] d_rem_reg;    // data bytes still to combine

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    logic [7:0]       dout_reg;
    logic             dout_valid_reg;

    logic             in_run;
    logic             fifo_full;
    logic             fifo_empty;
    logic             out_free;
    logic             push;
    logic             fire;
    logic [7:0]       fifo_head;

    // ------------------------------------------------------------------
    // Handshake decode. ks_ready looks only at registered state. A pop in
    // the same cycle therefore does not reopen a full FIFO until the next
    // cycle.
    // ------------------------------------------------------------------
    assign in_run     = (state_reg == ST_RUN);
    assign fifo_full  = (count_reg == CNT_FULL);
    assign fifo_empty = (count_reg == CNT_ZERO);
    assign out_free   = ~dout_valid_reg | dout_ready;

    assign ks_ready   = in_run & ~fifo_full & (ks_rem_reg != LEN_ZERO);
    assign din_ready  = in_run & ~fifo_empty & out_free;

    assign push       = ks_valid & ks_ready;
    assign fire       = din_valid & din_ready;

    // There is no bypass path. A byte pushed while the FIFO is empty can
    // only be popped on the following cycle.
    assign fifo_head  = fifo_mem[rd_ptr_reg];

    assign busy       = (state_reg != ST_IDLE);
    assign done       = (state_reg == ST_DONE);
    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;

    // ------------------------------------------------------------------
    // FIFO occupancy
    // ------------------------------------------------------------------
    always_comb begin
        count_next = count_reg;
        case ({push, fire})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    // The storage has no reset. Occupancy is tracked by the pointers and
    // the count, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= ks_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            // The depth is a power of two, so the pointers wrap naturally.
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (fire) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            count_reg <= count_next;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and remaining-byte counters. Both counters are decremented
    // only under a handshake that requires them to be nonzero, so they never
    // wrap.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            ks_rem_reg <= '0;
            d_rem_reg  <= '0;
        end else begin
            if (push) begin
                ks_rem_reg <= ks_rem_reg - LEN_ONE;
            end
            if (fire) begin
                d_rem_reg <= d_rem_reg - LEN_ONE;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        ks_rem_reg <= msg_len;
                        d_rem_reg  <= msg_len;
                        state_reg  <= (msg_len == LEN_ZERO) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (fire && (d_rem_reg == LEN_ONE)) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (dout_valid_reg && dout_ready) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output register. It holds its value while downstream stalls. A new
    // byte may replace the current one in the same cycle the current one is
    // taken, which gives one byte per cycle when streaming.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_reg       <= 8'h00;
            dout_valid_reg <= 1'b0;
        end else begin
            if (fire) begin
                dout_reg       <= din ^ fifo_head;
                dout_valid_reg <= 1'b1;
            end else if (dout_ready) begin
                dout_valid_reg <= 1'b0;
            end
        end
    end

endmodule
